// File: rtl/mux_reg.sv
// Dual operand-selection register: two independent 4:1 source muxes, each
// feeding an enable-gated register that drives one ALU operand.
module mux_reg #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] inRs1,
    input  logic [WIDTH-1:0] inBusA,
    input  logic [WIDTH-1:0] inPC,
    input  logic [WIDTH-1:0] inRs2,
    input  logic [WIDTH-1:0] inBusB,
    input  logic [WIDTH-1:0] inImm,
    input  logic             Aenable,
    input  logic             Benable,
    input  logic [1:0]       Asel,
    input  logic [1:0]       Bsel,
    output logic [WIDTH-1:0] Aout,
    output logic [WIDTH-1:0] Bout
);

    logic [WIDTH-1:0] w_a_mux;
    logic [WIDTH-1:0] w_b_mux;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;

    // Source selection; code 11 yields zero on both sides.
    always_comb begin
        w_a_mux = '0;
        unique case (Asel)
            2'b00:   w_a_mux = inRs1;
            2'b01:   w_a_mux = inBusA;
            2'b10:   w_a_mux = inPC;
            default: w_a_mux = '0;
        endcase
    end

    always_comb begin
        w_b_mux = '0;
        unique case (Bsel)
            2'b00:   w_b_mux = inRs2;
            2'b01:   w_b_mux = inBusB;
            2'b10:   w_b_mux = inImm;
            default: w_b_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a <= '0;
        end else if (Aenable) begin
            r_a <= w_a_mux;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_b <= '0;
        end else if (Benable) begin
            r_b <= w_b_mux;
        end
    end

    assign Aout = r_a;
    assign Bout = r_b;

endmodule

// File: tb/tb_mux_reg.sv
// Scoreboard bench for mux_reg: stimulus queues expected operand pairs,
// a monitor process pops and compares them against Aout/Bout.
module tb_mux_reg;

    localparam int unsigned WIDTH = 32;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] inRs1, inBusA, inPC, inRs2, inBusB, inImm;
    logic             Aenable, Benable;
    logic [1:0]       Asel, Bsel;
    logic [WIDTH-1:0] Aout, Bout;

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] q_a[$];
    logic [WIDTH-1:0] q_b[$];
    string            q_name[$];
    event             ev_push;
    bit               stim_done = 0;

    mux_reg #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .inRs1   (inRs1),
        .inBusA  (inBusA),
        .inPC    (inPC),
        .inRs2   (inRs2),
        .inBusB  (inBusB),
        .inImm   (inImm),
        .Aenable (Aenable),
        .Benable (Benable),
        .Asel    (Asel),
        .Bsel    (Bsel),
        .Aout    (Aout),
        .Bout    (Bout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expect_out(input string name, input logic [WIDTH-1:0] a,
                              input logic [WIDTH-1:0] b);
        q_a.push_back(a);
        q_b.push_back(b);
        q_name.push_back(name);
        -> ev_push;
    endtask

    // Advance past the next rising edge and let outputs settle.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Monitor: drain every queued expectation against the live outputs.
    initial begin
        logic [WIDTH-1:0] ea, eb;
        string            nm;
        forever begin
            @(ev_push);
            while (q_a.size() > 0) begin
                ea = q_a.pop_front();
                eb = q_b.pop_front();
                nm = q_name.pop_front();
                checks++;
                if (Aout !== ea || Bout !== eb) begin
                    failures++;
                    $display("FAIL %s: Aout=%0d Bout=%0d expected Aout=%0d Bout=%0d",
                             nm, Aout, Bout, ea, eb);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: stimulus did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0; Aenable = 1'b0; Benable = 1'b0; Asel = 2'b00; Bsel = 2'b00;
        inRs1 = '0; inBusA = '0; inPC = '0; inRs2 = '0; inBusB = '0; inImm = '0;

        // Asynchronous reset mid-cycle, then held across edges with enables high.
        #7;
        reset = 1'b1;
        #1;
        expect_out("reset_async", 0, 0);
        Aenable = 1'b1; Benable = 1'b1;
        step();
        expect_out("reset_hold_en1", 0, 0);
        step();
        expect_out("reset_hold_en2", 0, 0);

        // Register-file sources.
        Aenable = 1'b0; Benable = 1'b0;
        reset = 1'b0;
        inRs1 = 35; inRs2 = 84; inBusA = 22; inBusB = 67; inPC = 52; inImm = 12;
        step();
        expect_out("rf_hold_disabled", 0, 0);
        Aenable = 1'b1; Benable = 1'b1;
        step();
        expect_out("rf_load", 35, 84);
        Aenable = 1'b0; Benable = 1'b0;
        inRs1 = 99; inRs2 = 98;
        step();
        expect_out("rf_hold_after_change", 35, 84);

        // Bus sources; a mid-cycle select change must not show before the edge.
        Aenable = 1'b1; Benable = 1'b1;
        Asel = 2'b01; Bsel = 2'b01;
        #1;
        expect_out("bus_no_comb_path", 35, 84);
        step();
        expect_out("bus_load", 22, 67);
        Aenable = 1'b0; Benable = 1'b0;
        inBusA = 77; inBusB = 88;
        step();
        expect_out("bus_hold", 22, 67);

        // Reset pulse between edges.
        reset = 1'b1;
        #1;
        expect_out("reset_mid_op", 0, 0);
        #1;
        reset = 1'b0;
        step();
        expect_out("reset_release_hold", 0, 0);

        // PC / immediate sources.
        Asel = 2'b10; Bsel = 2'b10;
        step();
        expect_out("pc_imm_disabled", 0, 0);
        Aenable = 1'b1; Benable = 1'b1;
        step();
        expect_out("pc_imm_load", 52, 12);

        // Independence and zero select.
        Aenable = 1'b1; Benable = 1'b0; Asel = 2'b11;
        step();
        expect_out("a_zero_b_hold", 0, 12);
        inRs2 = 84;
        Aenable = 1'b0; Benable = 1'b1; Bsel = 2'b00; Asel = 2'b10;
        step();
        expect_out("b_rs2_a_hold", 0, 84);
        Aenable = 1'b1; Benable = 1'b0; Bsel = 2'b01;
        step();
        expect_out("a_pc_b_hold", 52, 84);

        // Reset asserted at an edge with enables high keeps both at zero,
        // and the first load follows the first edge after release.
        Aenable = 1'b1; Benable = 1'b1; Asel = 2'b00; Bsel = 2'b10;
        reset = 1'b1;
        step();
        expect_out("reset_over_enable", 0, 0);
        reset = 1'b0;
        step();
        expect_out("first_load_after_release", 99, 12);

        #3;
        stim_done = 1'b1;
        checks++;
        if (q_a.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: pending=%0d expected pending=0", q_a.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_reg.md
Name: mux_reg

Overview:
- Dual operand-selection register for the RISC-V PE datapath.
- Each side (A and B) has a 4:1 source mux feeding an enable-gated 32-bit register.
- A side selects between rs1, bus A and PC. B side selects between rs2, bus B and immediate.
- The registered Aout/Bout drive the ALU operand inputs. The block sits between the register-file/bus interface and the execute stage.

Parameters:
- WIDTH, 32, data width of all inputs, registers and outputs.

Ports:
- clk  input  1  system clock; all register updates on its rising edge.
- reset  input  1  asynchronous, active-high reset; clears both registers.
- inRs1  input  WIDTH  A-side source 0: register-file rs1 value.
- inBusA  input  WIDTH  A-side source 1: interconnect bus A value.
- inPC  input  WIDTH  A-side source 2: program counter.
- inRs2  input  WIDTH  B-side source 0: register-file rs2 value.
- inBusB  input  WIDTH  B-side source 1: interconnect bus B value.
- inImm  input  WIDTH  B-side source 2: decoded immediate.
- Aenable  input  1  load enable for the A register.
- Benable  input  1  load enable for the B register.
- Asel  input  2  A-side mux select.
- Bsel  input  2  B-side mux select.
- Aout  output  WIDTH  registered A operand.
- Bout  output  WIDTH  registered B operand.

Behaviour:
- One clock (clk). Reset is asynchronous and active-high (reset).
- A mux (combinational): Asel 00 selects inRs1, 01 selects inBusA, 10 selects inPC, 11 selects all-zeros.
- B mux (combinational): Bsel 00 selects inRs2, 01 selects inBusB, 10 selects inImm, 11 selects all-zeros.
- A register:
  - When reset=1, Aout is cleared to 0 immediately, without waiting for a clock edge.
  - Otherwise, on a rising clk edge with Aenable=1, Aout takes the A mux output.
  - With Aenable=0, Aout holds its value.
- B register: identical behaviour, using Benable, Bsel and Bout.
- The A and B sides are fully independent. Each may load, hold or select any source regardless of the other.
- Latency: 1 cycle. A value presented with enable=1 appears on the output just after the next rising edge.
- Priority: reset overrides enable. If reset is high at a clock edge, the register stays 0 even when enable=1.
- Reset release: the first load happens on the first rising edge where reset=0 and enable=1.
- Select or data changes while enable=0 have no effect on the outputs.
- Select or data changes while enable=1 take effect only at the next rising edge. Outputs never show combinational mux glitches.
- No width conversion: data passes unmodified, no sign extension, no arithmetic.
- Outputs are registered only. No combinational path from inputs to Aout/Bout.

Test Plan:
- Reset: assert reset with all inputs 0, mid-cycle.
  -> Aout=0 and Bout=0 immediately.
  -> Both stay 0 across clock edges while reset=1, even with enables high.
- Register-file load: inRs1=35, inRs2=84, inBusA=22, inBusB=67, inPC=52, inImm=12, Asel=Bsel=00, enables 0.
  -> Outputs hold 0.
  -> Raise both enables for one edge: Aout=35, Bout=84.
  -> Drop enables and change inputs: outputs hold 35/84.
- Bus load: Asel=Bsel=01, enables=1.
  -> After the next edge, Aout=22, Bout=67.
  -> Deassert enables: values hold.
- Reset mid-operation: with Aout=22, Bout=67, pulse reset between clock edges.
  -> Both outputs go to 0 asynchronously.
  -> After release with enables=0, they remain 0.
- PC/immediate load: Asel=Bsel=10.
  -> With enables=0, outputs stay 0.
  -> After enables=1 and an edge, Aout=52, Bout=12.
- Independence and select 11:
  - Aenable=1, Benable=0, Asel=11 -> Aout=0, Bout holds.
  - Then Benable=1, Bsel=00 -> Bout=84, Aout unaffected.
